// File: rtl/spi_slave.sv
// SPI slave front-end for a single-port RAM: deserialises command/address/data
// words from MOSI and serialises RAM read data back on MISO.
module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic [2:0]           state_dbg,
    output logic                 rd_addr_done
);
    // Handshakes: rx_valid is a one-cycle strobe with no back-pressure; tx_valid is
    // sampled only while a READ_DATA frame waits for read data, and is ignored otherwise.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam int WORD_W  = ADDR_SIZE + 2;
    localparam int BIT_CW  = $clog2(WORD_W);
    localparam int MISO_CW = $clog2(ADDR_SIZE);
    localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(WORD_W - 1);
    localparam logic [MISO_CW-1:0] LAST_MISO = MISO_CW'(ADDR_SIZE - 1);

    state_t               state;
    state_t               next_state;
    logic [BIT_CW-1:0]    bit_cnt;
    logic [WORD_W-2:0]    shift_in;
    logic                 word_done;
    logic [ADDR_SIZE-1:0] tx_shift;
    logic [MISO_CW-1:0]   miso_cnt;
    logic                 miso_active;
    logic                 tx_sent;
    logic                 in_payload;
    logic                 tx_load;

    assign in_payload = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign tx_load    = (state == READ_DATA) && word_done && !miso_active && !tx_sent
                        && tx_valid && !SS_n;
    assign MISO       = miso_active & tx_shift[ADDR_SIZE-1];
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!SS_n) next_state = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)              next_state = IDLE;
                else if (!MOSI)        next_state = WRITE;
                else if (rd_addr_done) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
            bit_cnt      <= '0;
            shift_in     <= '0;
            word_done    <= 1'b0;
            tx_shift     <= '0;
            miso_cnt     <= '0;
            miso_active  <= 1'b0;
            tx_sent      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // The 10th bit is still captured when SS_n rises on the same edge.
            if (in_payload && !word_done) begin
                shift_in <= {shift_in[WORD_W-3:0], MOSI};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data   <= {shift_in, MOSI};
                    rx_valid  <= 1'b1;
                    word_done <= 1'b1;
                    if (state == READ_ADD) rd_addr_done <= 1'b1;
                end
            end

            if (tx_load) begin
                tx_shift    <= tx_data;
                miso_active <= 1'b1;
                miso_cnt    <= '0;
            end else if (miso_active) begin
                tx_shift <= tx_shift << 1;
                miso_cnt <= miso_cnt + 1'b1;
                if (miso_cnt == LAST_MISO) begin
                    miso_active  <= 1'b0;
                    tx_sent      <= 1'b1;
                    rd_addr_done <= 1'b0;
                end
            end

            // Deselect or idle: drop any partial word and silence MISO.
            if (SS_n || state == IDLE) begin
                bit_cnt     <= '0;
                word_done   <= 1'b0;
                tx_shift    <= '0;
                miso_cnt    <= '0;
                miso_active <= 1'b0;
                tx_sent     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8: RAM address/data width; rx_data is ADDR_SIZE+2 bits.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SS_n  input  1  slave select, active-low; frames a transaction.
REQ-005 SHALL have port MOSI  input  1  serial data in, sampled on each clk edge, MSB first.
REQ-006 SHALL have port MISO  output  1  serial read data out, MSB first.
REQ-007 SHALL have port rx_data  output  ADDR_SIZE+2  parallel word to RAM: [9:8] command, [7:0] address/data.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port tx_data  input  ADDR_SIZE  read data returned by RAM.
REQ-010 SHALL have port tx_valid  input  1  qualifies tx_data.

Function
REQ-011 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, plus an internal rd_addr_done flag.
REQ-012 IDLE: SS_n=1 stays IDLE; SS_n=0 moves to CHK_CMD on the next edge.
REQ-013 CHK_CMD samples one selector bit on MOSI: 0 -> WRITE; 1 with rd_addr_done=0 -> READ_ADD; 1 with rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA shift exactly 10 payload bits from MOSI, one per edge, MSB first, through a 4-bit bit counter (0..9).
REQ-015 On the edge sampling payload bit 10, rx_data SHALL update to the full word and rx_valid SHALL be 1 for exactly that following cycle, then 0.
REQ-016 rx_data SHALL hold its last value between strobes; payload bits beyond the 10th in the same frame are ignored.
REQ-017 Completion of a READ_ADD frame (rx_valid issued) SHALL set rd_addr_done.
REQ-018 In READ_DATA after rx_valid, the block waits for tx_valid=1; on that edge it loads tx_data into an 8-bit output shift register.
REQ-019 Over the next 8 cycles MISO SHALL present tx_data[7] down to tx_data[0], one bit per cycle; MISO=0 at all other times.
REQ-020 After the 8th MISO bit, rd_addr_done SHALL clear; the FSM stays in READ_DATA with MISO=0 until SS_n=1.
REQ-021 tx_valid SHALL be ignored outside the READ_DATA wait window; without tx_valid the block waits indefinitely.
REQ-022 SS_n=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, clear the bit and MISO counters, drop the partial word (no rx_valid) and force MISO=0.
REQ-023 An aborted frame SHALL leave rd_addr_done unchanged.
REQ-024 If SS_n rises in the same cycle as the 10th payload bit, the bit is captured and rx_valid is issued; the FSM then goes to IDLE.
REQ-025 The payload's own [9:8] bits are forwarded unmodified; the selector bit is not checked against them.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, all counters and the shift register 0, regardless of clk.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release, operation resumes only on a new SS_n falling edge through IDLE.

Verification
REQ-028 Write address: SS_n=0, MOSI 0 then 0010100101 -> rx_data=0x0A5, one-cycle rx_valid after the 10th bit, MISO=0 throughout.
REQ-029 Write data: selector 0, payload 0100111100 -> rx_data=0x13C, single rx_valid pulse; extra MOSI bits before SS_n=1 produce no pulse.
REQ-030 Read: frame 1+1010100101 sets rd_addr_done -> rx_data=0x2A5; next frame 1+1100000000 -> rx_data=0x300; tx_valid=1, tx_data=0xA5 one cycle later -> MISO 1,0,1,0,0,1,0,1, then rd_addr_done=0.
REQ-031 Abort: SS_n=1 after 5 payload bits -> no rx_valid, FSM IDLE next edge, rx_data unchanged.
REQ-032 Read data without prior address: rd_addr_done=0, selector 1 -> FSM enters READ_ADD and no MISO activity follows tx_valid.
REQ-033 Async reset asserted between clk edges mid-READ_DATA shift -> MISO, rx_valid and rd_addr_done read 0 immediately, FSM IDLE.
